// File: rtl/fetch_prefetch_queue.sv
// Fetch stage with sequential prefetch into an instruction queue and a pipelined imem port.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_prefetch_queue #(
  parameter int unsigned          XLEN            = 32,
  parameter logic [XLEN-1:0]      RESET_PC        = XLEN'(32'h8000_0000),
  parameter int unsigned          QUEUE_DEPTH     = 4,
  parameter int unsigned          MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [XLEN-1:0] imem_resp_data_i,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic [XLEN-1:0] fetch_inst_o,
  output logic [31:0]     perf_inst_cnt_o,
  output logic [31:0]     perf_stall_cnt_o
);

  localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ST_IDLE, ST_RUN} st_e;

  // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
  // valid never waits for ready, and addr is held while valid is high until it is taken or redirected.
  st_e             st_q, st_d;
  logic            run;

  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   discard_q, discard_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q   [QUEUE_DEPTH];
  logic [XLEN-1:0] inst_mem_q [QUEUE_DEPTH];

  logic            req_valid;
  logic            fire;
  logic            resp_ok;
  logic            push;
  logic            fetch_valid;
  logic            deq;

  // Run FSM: one idle cycle after reset release, then fetch forever.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) st_q <= ST_IDLE;
    else         st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: st_d = ST_RUN;
      ST_RUN:  st_d = ST_RUN;
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run = (st_q == ST_RUN);
  end

  // Request credit counts in-flight requests plus queued entries, so a response always has a slot.
  always_comb begin
    logic [31:0] occ;
    occ       = 32'(outstanding_q) + 32'(count_q);
    req_valid = run && (32'(outstanding_q) < MAX_OUTSTANDING) && (occ < QUEUE_DEPTH);
  end

  assign fire        = req_valid & imem_req_ready_i;
  assign resp_ok     = imem_resp_valid_i & (outstanding_q != '0);
  assign fetch_valid = (count_q != '0) & ~redirect_valid_i;
  assign deq         = fetch_valid & fetch_ready_i;
  assign push        = resp_ok & (discard_q == '0) & ~redirect_valid_i;

  always_comb begin
    outstanding_d = outstanding_q + OW'(fire) - OW'(resp_ok);
    discard_d     = discard_q;
    req_pc_d      = req_pc_q;
    resp_pc_d     = resp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (redirect_valid_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      discard_d = outstanding_d;
      req_pc_d  = redirect_pc_i;
      resp_pc_d = redirect_pc_i;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else begin
      if (resp_ok && (discard_q != '0)) discard_d = discard_q - OW'(1);
      if (fire) req_pc_d = req_pc_q + XLEN'(4);
      if (push) resp_pc_d = resp_pc_q + XLEN'(4);
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(deq);
      count_d  = count_q + CW'(push) - CW'(deq);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_pc_q      <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      req_pc_q      <= req_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_resp_data_i;
    end
  end

  // Data outputs read zero while nothing meaningful is presented, so reset drives every output low.
  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = run ? req_pc_q : '0;
  assign fetch_valid_o    = fetch_valid;
  assign fetch_pc_o       = (count_q != '0) ? pc_mem_q[rd_ptr_q]   : '0;
  assign fetch_inst_o     = (count_q != '0) ? inst_mem_q[rd_ptr_q] : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    inst_cnt_d  = inst_cnt_q + 32'(deq);
    stall_cnt_d = stall_cnt_q + 32'(fetch_ready_i & ~fetch_valid);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      inst_cnt_q  <= inst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_inst_cnt_o  = inst_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`else
  assign perf_inst_cnt_o  = 32'h0;
  assign perf_stall_cnt_o = 32'h0;
`endif

  // A response with nothing in flight is a memory-side protocol violation; it is ignored above.
  a_resp_has_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_resp_valid_i |-> (outstanding_q != '0));

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(count_q) <= QUEUE_DEPTH);

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: random memory/decode timing, stream-level reference model.
module tb_fetch_prefetch_queue;
  localparam int          XLEN     = 32;
  localparam int          QD       = 4;
  localparam int          MO       = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_resp_valid_i = 1'b0;
  logic [31:0] imem_resp_data_i = '0;
  logic        fetch_valid_o;
  logic        fetch_ready_i = 1'b0;
  logic [31:0] fetch_pc_o;
  logic [31:0] fetch_inst_o;
  logic [31:0] perf_inst_cnt_o;
  logic [31:0] perf_stall_cnt_o;

  fetch_prefetch_queue #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i), .imem_resp_data_i(imem_resp_data_i),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i),
    .fetch_pc_o(fetch_pc_o), .fetch_inst_o(fetch_inst_o),
    .perf_inst_cnt_o(perf_inst_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Scoreboard state: memory in-flight addresses, expected decode stream {pc, inst}
  logic [31:0] mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] model_req_pc = RESET_PC;
  int          ready_pct = 100, resp_pct = 100, dec_pct = 100;
  int          fire_cnt = 0, deq_cnt = 0, stall_cnt = 0;
  logic        prev_valid = 1'b0, prev_fire = 1'b0, prev_redir = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        mon_fire, mon_deq;
  logic [63:0] mon_e;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check32("rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    check32("rst_req_addr", imem_req_addr_o, 32'd0);
    check32("rst_fetch_valid", {31'b0, fetch_valid_o}, 32'd0);
    check32("rst_fetch_pc", fetch_pc_o, 32'd0);
    check32("rst_fetch_inst", fetch_inst_o, 32'd0);
    check32("rst_perf_inst", perf_inst_cnt_o, 32'd0);
    check32("rst_perf_stall", perf_stall_cnt_o, 32'd0);
  endtask

  // Driver: memory and decode timing, applied just after each rising edge
  always @(posedge clk_i) begin
    #1;
    imem_req_ready_i = ($urandom_range(1, 100) <= ready_pct);
    if (rst_ni && mem_q.size() > 0 && $urandom_range(1, 100) <= resp_pct) begin
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = mem_data(mem_q[0]);
    end else begin
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = $urandom;
    end
    fetch_ready_i = ($urandom_range(1, 100) <= dec_pct);
  end

  // Monitor: checks on the falling edge, updates the stream model
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mem_q.delete();
      exp_q.delete();
      model_req_pc = RESET_PC;
      deq_cnt      = 0;
      stall_cnt    = 0;
      prev_valid   = 1'b0;
    end else begin
      mon_fire = imem_req_valid_o & imem_req_ready_i;
      mon_deq  = fetch_valid_o & fetch_ready_i;
      if (redirect_valid_i) check32("valid_in_redirect", {31'b0, fetch_valid_o}, 32'd0);
      if (imem_req_valid_o) check32("credit", (mem_q.size() < MO) ? 32'd1 : 32'd0, 32'd1);
      if (prev_valid && !prev_fire && !prev_redir) begin
        check32("req_hold_valid", {31'b0, imem_req_valid_o}, 32'd1);
        check32("req_hold_addr", imem_req_addr_o, prev_addr);
      end
      if (mon_deq) begin
        deq_cnt++;
        if (exp_q.size() == 0) begin
          check32("unexpected_deliver_pc", fetch_pc_o, 32'hxxxx_xxxx);
        end else begin
          mon_e = exp_q.pop_front();
          check32("fetch_pc", fetch_pc_o, mon_e[63:32]);
          check32("fetch_inst", fetch_inst_o, mon_e[31:0]);
        end
      end
      if (fetch_ready_i && !fetch_valid_o) stall_cnt++;
      if (imem_resp_valid_i && mem_q.size() > 0) void'(mem_q.pop_front());
      if (mon_fire) begin
        check32("req_addr", imem_req_addr_o, model_req_pc);
        mem_q.push_back(imem_req_addr_o);
        if (!redirect_valid_i) exp_q.push_back({model_req_pc, mem_data(model_req_pc)});
        model_req_pc = model_req_pc + 32'd4;
        fire_cnt++;
      end
      if (redirect_valid_i) begin
        exp_q.delete();
        model_req_pc = redirect_pc_i;
      end
      prev_valid = imem_req_valid_o;
      prev_fire  = mon_fire;
      prev_redir = redirect_valid_i;
      prev_addr  = imem_req_addr_o;
    end
  end

  task automatic do_redirect(input logic [31:0] tgt);
    @(posedge clk_i); #1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = tgt;
    @(posedge clk_i); #1;
    redirect_valid_i = 1'b0;
  endtask

  // Stimulus
  initial begin
    int cnt;
    int f0;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs();

    // Release: first request, then first decode-visible instruction
    @(posedge clk_i); #1 rst_ni = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      cnt++;
      @(negedge clk_i);
      if (fetch_valid_o) break;
    end
    check32("first_valid_latency", cnt, 32'd3);
    repeat (20) @(posedge clk_i);

    // Decode stalled: the queue fills with exactly QD requests
    dec_pct = 0;
    do_redirect(32'h8000_0200);
    f0 = fire_cnt;
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    check32("fill_fires", fire_cnt - f0, QD);
    check32("fill_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    check32("fill_fetch_valid", {31'b0, fetch_valid_o}, 32'd1);
    @(posedge clk_i); dec_pct = 100;
    @(posedge clk_i); dec_pct = 0;
    f0 = fire_cnt;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    check32("one_deq_one_fire", fire_cnt - f0, 32'd1);

    // Two requests held in memory, redirect drops both
    ready_pct = 100; resp_pct = 0; dec_pct = 100;
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    check32("two_outstanding", mem_q.size(), 32'd2);
    @(posedge clk_i); #1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0100;
    @(posedge clk_i);
    resp_pct = 100;
    #1 redirect_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (fetch_valid_o) break;
    end
    check32("post_redirect_pc", fetch_pc_o, 32'h8000_0100);
    check32("post_redirect_inst", fetch_inst_o, mem_data(32'h8000_0100));

    // Redirect during full-rate traffic (fire and response in the same cycle)
    repeat (6) @(posedge clk_i);
    do_redirect(32'h8000_0400);
    repeat (10) @(posedge clk_i);

    // Reset mid-burst
    ready_pct = 70; resp_pct = 70; dec_pct = 70;
    repeat (30) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (20) @(posedge clk_i);

    // Random traffic with random redirects (wrapping and unaligned targets included)
    for (int blk = 0; blk < 40; blk++) begin
      ready_pct = $urandom_range(20, 100);
      resp_pct  = $urandom_range(20, 100);
      dec_pct   = $urandom_range(0, 100);
      for (int c = 0; c < 50; c++) begin
        @(posedge clk_i); #1;
        redirect_valid_i = ($urandom_range(0, 99) < 4);
        case ($urandom_range(0, 3))
          0:       redirect_pc_i = 32'hFFFF_FFF8;
          1:       redirect_pc_i = $urandom;
          2:       redirect_pc_i = $urandom & 32'hFFFF_FFFC;
          default: redirect_pc_i = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
        endcase
      end
    end
    @(posedge clk_i); #1 redirect_valid_i = 1'b0;

    // Drain: stop issuing, deliver everything expected
    ready_pct = 0; resp_pct = 100; dec_pct = 100;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && mem_q.size() == 0) break;
    end
    check32("drain_empty", exp_q.size(), 32'd0);

    @(posedge clk_i); #2;
`ifdef FETCH_PERF_CNT_EN
    check32("perf_inst", perf_inst_cnt_o, deq_cnt);
    check32("perf_stall", perf_stall_cnt_o, stall_cnt);
`else
    check32("perf_inst_off", perf_inst_cnt_o, 32'd0);
    check32("perf_stall_off", perf_stall_cnt_o, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
